inst_fetch_unit: RTL
====================

INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, byte-address width of the program memory and PC.
REQ-002 SHALL have parameter INST_BYTES, default 4, number of bytes per instruction and the PC step.
REQ-003 SHALL have parameter DEPTH, default 64, number of instructions stored; MEM_BYTES = DEPTH*INST_BYTES SHALL be <= 2**ADDR_W (elaboration error otherwise).
REQ-004 SHALL have ports:
- i_clk  in  1  sole clock, all state updates on rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_prog_mode  in  1  request program-load mode.
- i_run  in  1  request execution.
- i_wr_valid  in  1  program byte write strobe.
- o_wr_ready  out  1  loader accepts a byte.
- i_wr_addr  in  ADDR_W  byte address of write.
- i_wr_data  in  8  byte to write.
- i_stall  in  1  hold fetch outputs.
- i_branch_valid  in  1  redirect fetch.
- i_branch_target  in  ADDR_W  redirect byte address.
- o_inst  out  8*INST_BYTES  fetched instruction.
- o_pc  out  ADDR_W  byte address of o_inst.
- o_inst_valid  out  1  o_inst/o_pc hold a fetched instruction.
- o_fault  out  1  sticky fault flag.
- o_state  out  2  state: 0 IDLE, 1 PROG, 2 RUN, 3 FAULT.

Function
REQ-005 SHALL hold a byte-wide memory of MEM_BYTES entries and an internal fetch pointer fptr (ADDR_W bits).
REQ-006 IDLE: i_prog_mode=1 -> PROG; else i_run=1 -> RUN with fptr<=0; else stay. i_prog_mode has priority over i_run.
REQ-007 PROG: o_wr_ready=1 (0 in every other state); on i_wr_valid&o_wr_ready, mem[i_wr_addr]<=i_wr_data when i_wr_addr<MEM_BYTES; out-of-range writes are accepted and dropped without fault.
REQ-008 PROG: i_prog_mode=0 -> IDLE; fptr unchanged.
REQ-009 RUN, per edge, priority order: (a) i_prog_mode=1 -> PROG, o_inst_valid<=0; (b) i_run=0 -> IDLE, o_inst_valid<=0; (c) i_branch_valid=1 -> fptr<=i_branch_target, o_inst_valid<=0 (flush, applies even when stalled); (d) i_stall=1 -> o_inst, o_pc, o_inst_valid, fptr all held; (e) otherwise fetch.
REQ-010 Fetch: o_inst[8k+7:8k]<=mem[fptr+k] for k=0..INST_BYTES-1 (little-endian), o_pc<=fptr, o_inst_valid<=1, fptr<=(fptr+INST_BYTES) mod MEM_BYTES; latency one edge from fptr to o_inst.
REQ-011 Wrap-around: fetching the last word (fptr=MEM_BYTES-INST_BYTES) SHALL set fptr<=0, no fault.
REQ-012 Branch target with target >= MEM_BYTES or target mod INST_BYTES != 0 SHALL go to FAULT instead of (c): o_fault<=1, o_inst_valid<=0, fptr unchanged.
REQ-013 FAULT: o_inst_valid=0, o_wr_ready=0, o_fault=1; all inputs ignored; exit only through i_rst.
REQ-014 o_inst and o_pc SHALL retain their last values whenever o_inst_valid=0.

Reset
REQ-015 i_rst=1 at an edge SHALL force state IDLE, fptr=0, o_pc=0, o_inst=0, o_inst_valid=0, o_fault=0, o_wr_ready=0, in any state including mid-fetch or mid-write; a write coincident with reset is dropped.
REQ-016 Reset SHALL NOT clear memory contents; memory is undefined until written.

Verification (ADDR_W=8, INST_BYTES=4, DEPTH=16, MEM_BYTES=64)
REQ-017 Load: PROG, write bytes 0x11,0x22,0x33,0x44 to addr 0..3, exit, i_run=1 -> two edges after RUN entry o_inst=0x44332211, o_pc=0, o_inst_valid=1.
REQ-018 Sequence/wrap: run 17 unstalled fetches from RUN entry -> o_pc sequence 0,4,...,60,0; o_fault stays 0.
REQ-019 Stall/branch: stall 3 cycles at o_pc=8 -> outputs frozen at o_pc=8; branch to 0x20 while stalled -> next edge o_inst_valid=0, following edge o_pc=0x20, valid=1.
REQ-020 Fault: branch to 0x22 (misaligned), separately to 0x40 (out of range) -> o_state=3, o_fault=1, valid=0; i_run/i_prog_mode toggles ignored until i_rst.
REQ-021 Priority/reset: in IDLE assert i_prog_mode and i_run together -> PROG; write to addr 0x50 -> dropped, o_fault=0; i_rst mid-RUN -> all outputs per REQ-015 next edge, previously loaded bytes still readable after re-entering RUN.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: byte-loadable program memory plus a sequential fetcher with branch redirect.
// Latency: one clock edge from fetch pointer to o_inst/o_pc/o_inst_valid.
// Backpressure: i_stall freezes the outputs and the pointer; a branch still flushes while stalled.
module inst_fetch_unit #(
    parameter int ADDR_W     = 8,
    parameter int INST_BYTES = 4,
    parameter int DEPTH      = 64
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_prog_mode,
    input  logic                    i_run,
    input  logic                    i_wr_valid,
    output logic                    o_wr_ready,
    input  logic [ADDR_W-1:0]       i_wr_addr,
    input  logic [7:0]              i_wr_data,
    input  logic                    i_stall,
    input  logic                    i_branch_valid,
    input  logic [ADDR_W-1:0]       i_branch_target,
    output logic [8*INST_BYTES-1:0] o_inst,
    output logic [ADDR_W-1:0]       o_pc,
    output logic                    o_inst_valid,
    output logic                    o_fault,
    output logic [1:0]              o_state
);

    localparam int MEM_BYTES = DEPTH * INST_BYTES;
    localparam int IDX_W     = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
    // One extra bit so the limit itself is representable when memory fills the address space.
    localparam logic [ADDR_W:0]   MEM_LIM = (ADDR_W+1)'(MEM_BYTES);
    localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(INST_BYTES);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(MEM_BYTES - INST_BYTES);

    generate
        if (MEM_BYTES > (2 ** ADDR_W)) begin : g_size_chk
            $error("inst_fetch_unit: DEPTH*INST_BYTES exceeds the ADDR_W address space");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PROG  = 2'd1,
        S_RUN   = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [7:0]              mem [MEM_BYTES];
    logic [ADDR_W-1:0]       fptr;
    logic [8*INST_BYTES-1:0] fetch_word;
    logic [IDX_W-1:0]        fidx;

    logic wr_fire;
    logic branch_bad;
    logic do_fetch;
    logic do_branch;
    logic do_fptr_clr;
    logic do_clr_valid;
    logic do_fault;

    assign o_wr_ready = (state == S_PROG);
    assign o_state    = state;
    assign fidx       = fptr[IDX_W-1:0];

    // Out-of-range writes are still handshaken; they simply never reach the array.
    assign wr_fire = o_wr_ready && i_wr_valid && !i_rst && ({1'b0, i_wr_addr} < MEM_LIM);

    assign branch_bad = ({1'b0, i_branch_target} >= MEM_LIM) ||
                        ((i_branch_target % STEP) != '0);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath control decode; RUN checks mode changes before branch before stall.
    always_comb begin
        state_nxt    = state;
        do_fetch     = 1'b0;
        do_branch    = 1'b0;
        do_fptr_clr  = 1'b0;
        do_clr_valid = 1'b0;
        do_fault     = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_prog_mode) begin
                    state_nxt = S_PROG;
                end else if (i_run) begin
                    state_nxt   = S_RUN;
                    do_fptr_clr = 1'b1;
                end
            end
            S_PROG: begin
                if (!i_prog_mode) begin
                    state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (i_prog_mode) begin
                    state_nxt    = S_PROG;
                    do_clr_valid = 1'b1;
                end else if (!i_run) begin
                    state_nxt    = S_IDLE;
                    do_clr_valid = 1'b1;
                end else if (i_branch_valid) begin
                    do_clr_valid = 1'b1;
                    if (branch_bad) begin
                        state_nxt = S_FAULT;
                        do_fault  = 1'b1;
                    end else begin
                        do_branch = 1'b1;
                    end
                end else if (!i_stall) begin
                    do_fetch = 1'b1;
                end
            end
            default: begin
                state_nxt = S_FAULT;
            end
        endcase
    end

    // Program memory write port; contents survive reset.
    always_ff @(posedge i_clk) begin
        if (wr_fire) begin
            mem[i_wr_addr[IDX_W-1:0]] <= i_wr_data;
        end
    end

    // Little-endian assembly of the instruction at the fetch pointer.
    always_comb begin
        fetch_word = '0;
        for (int k = 0; k < INST_BYTES; k++) begin
            fetch_word[8*k +: 8] = mem[fidx + IDX_W'(k)];
        end
    end

    // Fetch pointer, output registers and sticky fault flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fptr         <= '0;
            o_pc         <= '0;
            o_inst       <= '0;
            o_inst_valid <= 1'b0;
            o_fault      <= 1'b0;
        end else begin
            if (do_fptr_clr) begin
                fptr <= '0;
            end
            if (do_branch) begin
                fptr <= i_branch_target;
            end
            if (do_clr_valid) begin
                o_inst_valid <= 1'b0;
            end
            if (do_fault) begin
                o_fault <= 1'b1;
            end
            if (do_fetch) begin
                o_inst       <= fetch_word;
                o_pc         <= fptr;
                o_inst_valid <= 1'b1;
                fptr         <= (fptr == LAST) ? '0 : fptr + STEP;
            end
        end
    end

endmodule
